// File: rtl/mux_ctrl_pkg.sv
// rtl/mux_ctrl_pkg.sv - shared constants and types for the mux round-robin scheduler
package mux_ctrl_pkg;

  localparam int N_REQ     = 16;
  localparam int SEL_W     = $clog2(N_REQ);
  localparam int MAX_BURST = 8;

  typedef enum logic {IDLE, GRANT} sched_state_t;
  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_16x1.sv
// rtl/mux_16x1.sv - 16-to-1 single-bit mux whose output is forced low while rstn is low
module mux_16x1 (
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  input  logic        rstn,
  output logic        out
);

  assign out = rstn & in[sel];

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-priority encoder: first set req bit at or after ptr, wrapping
module rr_pick
  import mux_ctrl_pkg::*;
#(
  parameter int N = N_REQ,
  parameter int W = SEL_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    // Scan from the far end back toward ptr so the nearest hit is written last.
    for (int j = N - 1; j >= 0; j--) begin
      pos = {1'b0, ptr} + (W+1)'(j);
      if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
      if (req[pos[W-1:0]]) begin
        found = 1'b1;
        idx   = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// rtl/mux_rr_sched.sv - round-robin owner scheduler driving sel/rstn of the shared 16x1 mux
module mux_rr_sched
  import mux_ctrl_pkg::*;
#(
  parameter int N_REQ     = mux_ctrl_pkg::N_REQ,
  parameter int SEL_W     = $clog2(N_REQ),
  parameter int MAX_BURST = mux_ctrl_pkg::MAX_BURST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             mux_rstn,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(MAX_BURST - 1);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(N_REQ - 1);

  sched_state_t     state, state_d;
  logic [SEL_W-1:0] owner, owner_d, ptr, ptr_d, pick_idx;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             pick_found, rel;
  logic [N_REQ-1:0] gnt_d;
  logic [SEL_W-1:0] sel_d;
  logic             mux_rstn_d, busy_d;

  rr_pick #(.N(N_REQ), .W(SEL_W)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign rel = !req[owner] || (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      cnt   <= cnt_d;
      ptr   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state;
    owner_d = owner;
    cnt_d   = cnt;
    ptr_d   = ptr;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (en && pick_found) begin
          state_d = GRANT;
          owner_d = pick_idx;
        end
      end
      GRANT: begin
        cnt_d = cnt + 1'b1;
        // Pointer moves past the owner even on an early drop so it cannot re-win first.
        if (rel) begin
          state_d = IDLE;
          ptr_d   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d      = '0;
    sel_d      = sel;
    mux_rstn_d = 1'b0;
    busy_d     = 1'b0;
    if (state == GRANT) begin
      gnt_d      = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
      sel_d      = owner;
      mux_rstn_d = 1'b1;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      sel      <= '0;
      mux_rstn <= 1'b0;
      busy     <= 1'b0;
    end else begin
      gnt      <= gnt_d;
      sel      <= sel_d;
      mux_rstn <= mux_rstn_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_sched.sv
// tb/tb_mux_rr_sched.sv - scoreboard bench for mux_rr_sched feeding mux_16x1
module tb_mux_rr_sched;

  localparam int N   = 16;
  localparam int MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] req = '0;
  logic [15:0] din = '0;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        mux_rstn, busy, out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        rstn;
    logic        busy;
  } exp_t;

  exp_t expq[$];

  mux_rr_sched dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .gnt      (gnt),
    .sel      (sel),
    .mux_rstn (mux_rstn),
    .busy     (busy)
  );

  mux_16x1 u_mux (
    .in   (din),
    .sel  (sel),
    .rstn (mux_rstn),
    .out  (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: owner = -1 when idle; outputs after an edge show who owned the mux before it.
  initial begin
    int   m_owner, m_cnt, m_ptr, m_last_sel, cand;
    exp_t e;
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_last_sel = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_owner = -1; m_cnt = 0; m_ptr = 0; m_last_sel = 0;
        e = '{gnt: 16'h0, sel: 4'h0, rstn: 1'b0, busy: 1'b0};
      end else begin
        if (m_owner >= 0) begin
          m_last_sel = m_owner;
          e = '{gnt: 16'h1 << m_owner, sel: 4'(m_owner), rstn: 1'b1, busy: 1'b1};
          m_cnt++;
          if (!req[m_owner] || m_cnt == MAX) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
          end
        end else begin
          e = '{gnt: 16'h0, sel: 4'(m_last_sel), rstn: 1'b0, busy: 1'b0};
          if (en && req != 16'h0) begin
            for (int k = N - 1; k >= 0; k--) begin
              cand = (m_ptr + k) % N;
              if (req[cand]) m_owner = cand;
            end
            m_cnt = 0;
          end
        end
      end
      expq.push_back(e);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL scoreboard: no expectation queued at %0t", $time);
      end else begin
        e = expq.pop_front();
        chk("gnt", 32'(gnt), 32'(e.gnt));
        chk("sel", 32'(sel), 32'(e.sel));
        chk("mux_rstn", 32'(mux_rstn), 32'(e.rstn));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("mux_out", 32'(out), e.rstn ? 32'(din[e.sel]) : 32'h0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_gnt(input int idx);
    int n = 0;
    while (gnt[idx] !== 1'b1 && n < 60) begin
      step(1);
      n++;
    end
    if (gnt[idx] !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL wait_gnt%0d: no grant within %0d cycles", idx, n);
    end
  endtask

  task automatic do_reset();
    step(1);
    rst = 1'b1;
    req = '0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(2);
    rst = 1'b0;
    en  = 1'b1;
    step(5);

    // Single requester 4, two full bursts
    req = 16'h0010;
    step(20);
    do_reset();

    // All requesting: owners sweep 0..15 and wrap
    req = 16'hFFFF;
    din = 16'hA5A5;
    step(17 * (MAX + 1) + 2);
    do_reset();

    // Owner 0 drops early; 7 wins next, then 8 follows 7
    req = 16'h0081;
    wait_gnt(0);
    step(2);
    req = 16'h0080;
    wait_gnt(7);
    req = 16'hFFFF;
    step(25);
    do_reset();

    // en gating; dropping en mid-burst leaves the burst intact
    en  = 1'b0;
    req = 16'h0004;
    step(5);
    en = 1'b1;
    wait_gnt(2);
    en = 1'b0;
    step(12);
    en = 1'b1;
    do_reset();

    // Asynchronous reset in the middle of owner 9's burst
    req = 16'h0200;
    wait_gnt(9);
    step(3);
    chk("pre_rst_gnt", 32'(gnt), 32'h0200);
    rst = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt), 32'h0);
    chk("async_rstn", 32'(mux_rstn), 32'h0);
    chk("async_sel", 32'(sel), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    step(2);
    rst = 1'b0;
    step(15);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: req = 16'h0;
        1: req = 16'(1 << $urandom_range(0, 15));
        2: req = 16'($urandom) & 16'($urandom);
        default: req = 16'($urandom);
      endcase
      en  = ($urandom_range(0, 7) != 0);
      din = 16'($urandom);
      step($urandom_range(1, 6));
    end

    step(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_sched.md
# mux_rr_sched

Round-robin scheduler that shares the 16x1 single-bit mux among 16 requesters. Each cycle it decides which input owns the mux, drives the 4-bit select and the mux's active-low reset, and holds a grant for a bounded burst. It sits directly in front of `mux_16x1`: `sel` and `mux_rstn` connect straight to that mux's `sel` and `rstn` ports.

## Interface
- `N_REQ`, 16, number of requesters; must equal the mux input count.
- `SEL_W`, 4, select width, $clog2(N_REQ).
- `MAX_BURST`, 8, maximum consecutive grant cycles per owner; legal range 1..16.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  when low, no new grant starts; a burst already in progress completes normally.
- `req`  in  N_REQ  level request per input; bit i asks for mux input i.
- `gnt`  out  N_REQ  one-hot current owner; all zero when idle.
- `sel`  out  SEL_W  binary index of the owner; feeds the mux `sel`.
- `mux_rstn`  out  1  high only while a grant is active; low forces the mux output to 0.
- `busy`  out  1  high in GRANT state.

## Operation
- Two states: IDLE and GRANT. The state enum lives in the package.
- **IDLE**
  - If `en` is high and `req` is nonzero, go to GRANT.
  - `owner` becomes the first set `req` bit, searching from `ptr` upward and wrapping modulo N_REQ.
  - Load `cnt` with 0.
- **GRANT**
  - `cnt` increments each cycle.
  - Release when `req[owner]` is sampled low, or when `cnt == MAX_BURST-1`.
  - On release: go to IDLE and set `ptr = (owner+1) mod N_REQ`.
- `ptr` resets to 0. It only changes on release, so an owner that drops its request early still advances the pointer.
- **Registered outputs (not combinational)**
  - `gnt` = one-hot(owner) in GRANT, 0 in IDLE.
  - `sel` = owner in GRANT; in IDLE it holds its last value.
  - `mux_rstn` = 1 in GRANT, 0 otherwise.
  - `busy` = 1 in GRANT.
- Requests that arrive during GRANT are ignored until the next IDLE cycle. The current owner is never preempted.
- Dropping `en` has no effect mid-burst. It only blocks the IDLE→GRANT transition.
- Width rules:
  - `cnt` is $clog2(MAX_BURST+1) bits and never wraps, because release occurs at MAX_BURST-1.
  - The `ptr` increment wraps naturally in SEL_W bits when N_REQ = 2^SEL_W.
  - For non-power-of-two N_REQ, explicit modulo is required.
- **Reset values:** state=IDLE, `ptr`=0, `owner`=0, `cnt`=0, `gnt`=0, `sel`=0, `mux_rstn`=0, `busy`=0.
- **Reset mid-burst:** outputs return to reset values asynchronously and immediately. No grant resumes after reset deassertion until a fresh IDLE arbitration.

## Timing
- **Grant latency:** `req` sampled with state IDLE at edge t gives `gnt`/`sel`/`mux_rstn` valid after edge t+1. The mux output is then valid combinationally in that same cycle.
- **Burst length:** exactly MAX_BURST cycles of `mux_rstn=1` if the owner holds `req`. If `req[owner]` is low at edge k of the grant, the grant ends after that edge.
- **Turnaround:** exactly one IDLE cycle (`gnt`=0, `mux_rstn`=0) between consecutive grants, even when the same requester re-wins.
- **Fairness:** with all 16 requesting continuously, owners cycle 0,1,2…15,0. Each gets MAX_BURST cycles per MAX_BURST+1 cycle slot.
- **Simultaneous events:**
  - Release and a new `req` on the same edge: the new request is arbitrated in the following IDLE cycle.
  - `en` falling on the same edge as IDLE→GRANT: no grant starts (`en` is sampled).

## Structure
- Package `mux_ctrl_pkg`:
  - constants `N_REQ`, `SEL_W`, `MAX_BURST` defaults;
  - `typedef enum logic {IDLE, GRANT} sched_state_t`;
  - `typedef logic [SEL_W-1:0] sel_t`.
- Sub-module `rr_pick`:
  - combinational rotate-priority encoder;
  - inputs `req` and `ptr`; outputs `found` and the winning `idx` (sel_t);
  - implemented as a double-width rotate or a masked/unmasked two-pass search.
- Top level `mux_rr_sched`: state register, counter, pointer, output registers.
- Testbench instantiates `mux_rr_sched` driving `mux_16x1` to check end-to-end data flow.

## Test plan
- Reset, then `req`=16'h0000 for 5 cycles → `gnt`=0, `sel`=0, `mux_rstn`=0, `busy`=0 throughout.
- `req`=16'h0010 held, `en`=1 → `gnt`=16'h0010 and `sel`=4 one cycle later. Grant lasts 8 cycles, then 1 idle cycle, then `sel`=4 again.
- `req`=16'hFFFF held → owners 0,1,2,…,15,0 in order, each 8 cycles with 1-cycle gaps. Mux `in`=16'hA5A5 yields `out` = `in[sel]` during grants and 0 in gaps.
- `req`=16'h0081 with `ptr`=0: owner 0 drops `req` after 3 grant cycles → release. Next owner is 7, and `ptr` becomes 8 after that grant.
- `en`=0 with `req`=16'h0004 → no grant. Raise `en` → grant to 2 on the next edge. Drop `en` mid-burst → the burst runs its full 8 cycles.
- Assert `rst` at grant cycle 4 of owner 9 → `gnt`, `mux_rstn` and `sel` go to 0 before the next edge. After release, `req`=16'h0200 is granted from IDLE with `ptr`=0.
